// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// pipe_hazard_ctrl_pkg : shared stage indices, FSM encoding and hazard helper
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_hazard_ctrl_pkg;

  localparam int NSTAGE     = 5;
  localparam int STG_PC     = 0;
  localparam int STG_IFID   = 1;
  localparam int STG_IDEX   = 2;
  localparam int STG_EXMEM  = 3;
  localparam int STG_MEMWB  = 4;

  localparam int REG_ADDR_W = 5;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // x0 is hardwired zero, so a load targeting it can never create a dependency.
  function automatic logic load_use_hazard(
    input logic      ex_mem_read,
    input reg_addr_t ex_rd,
    input logic      rs1_re,
    input reg_addr_t rs1,
    input logic      rs2_re,
    input reg_addr_t rs2
  );
    return ex_mem_read && (ex_rd != '0) &&
           ((rs1_re && (rs1 == ex_rd)) || (rs2_re && (rs2 == ex_rd)));
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// ============================================================================
// sat_counter : event counter that sticks at all-ones instead of wrapping
// Rev 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             rstn,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : stall/flush sequencer and PC redirect for the 5-stage pipe
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              sys_clk,
  input  logic              rstn,
  input  logic              if_busy,
  input  logic              stallreq_mem,
  input  logic              id_rs1_re,
  input  logic              id_rs2_re,
  input  logic [4:0]        id_rs1_addr,
  input  logic [4:0]        id_rs2_addr,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rd_addr,
  input  logic              br_taken_ex,
  input  logic [31:0]       br_target_ex,
  input  logic              exc_req,
  input  logic [31:0]       exc_vector,
  output logic [4:0]        stall_o,
  output logic [4:0]        flush_o,
  output logic              pc_redirect_o,
  output logic [31:0]       pc_redirect_addr_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  state_e             state_q, state_d;
  logic [31:0]        target_q, target_d;

  logic [NSTAGE-1:0]  stall_d;
  logic [NSTAGE-1:0]  flush_d;
  logic               redirect_d;
  logic [31:0]        redirect_addr_d;

  logic               load_use;
  logic               run_redirect;
  logic [31:0]        run_target;
  logic [31:0]        drain_target;

  assign load_use = load_use_hazard(ex_mem_read, ex_rd_addr,
                                    id_rs1_re, id_rs1_addr,
                                    id_rs2_re, id_rs2_addr);

  // A memory stall freezes EX, so a taken branch waits there until it clears.
  assign run_redirect = exc_req || (br_taken_ex && !stallreq_mem);
  assign run_target   = exc_req ? exc_vector : br_target_ex;
  assign drain_target = exc_req ? exc_vector : target_q;

  always_comb begin
    state_d         = state_q;
    target_d        = target_q;
    stall_d         = '0;
    flush_d         = '0;
    redirect_d      = 1'b0;
    redirect_addr_d = '0;

    unique case (state_q)
      ST_RUN: begin
        if (run_redirect) begin
          flush_d[STG_IFID]  = 1'b1;
          flush_d[STG_IDEX]  = 1'b1;
          flush_d[STG_EXMEM] = exc_req;
          if (if_busy) begin
            // Fetch cannot be redirected mid-access; park the target until it lands.
            stall_d[STG_PC] = 1'b1;
            target_d        = run_target;
            state_d         = ST_DRAIN;
          end else begin
            redirect_d      = 1'b1;
            redirect_addr_d = run_target;
          end
        end else if (stallreq_mem) begin
          stall_d = 5'b01111;
          flush_d = 5'b10000;
        end else if (load_use) begin
          stall_d = 5'b00011;
          flush_d = 5'b00100;
        end else if (if_busy) begin
          stall_d[STG_PC]   = 1'b1;
          flush_d[STG_IFID] = 1'b1;
        end
      end

      ST_DRAIN: begin
        stall_d[STG_PC]   = 1'b1;
        flush_d[STG_IFID] = 1'b1;
        if (exc_req) begin
          target_d           = exc_vector;
          flush_d[STG_EXMEM] = 1'b1;
        end
        if (stallreq_mem) begin
          stall_d[STG_EXMEM] = 1'b1;
          flush_d[STG_MEMWB] = 1'b1;
        end
        if (!if_busy) begin
          stall_d[STG_PC] = 1'b0;
          redirect_d      = 1'b1;
          redirect_addr_d = drain_target;
          state_d         = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Nothing leaves the block while reset is held, even from a pending DRAIN.
    if (!rstn) begin
      stall_d         = '0;
      flush_d         = '0;
      redirect_d      = 1'b0;
      redirect_addr_d = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_q  <= ST_RUN;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  assign flush_o            = flush_d;
  assign stall_o            = stall_d & ~flush_d;
  assign pc_redirect_o      = redirect_d;
  assign pc_redirect_addr_o = redirect_addr_d;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .clear_i (1'b0),
    .inc_i   (|stall_o),
    .cnt_o   (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .clear_i (1'b0),
    .inc_i   (redirect_d),
    .cnt_o   (flush_cnt_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// tb_pipe_hazard_ctrl : directed self-checking bench for pipe_hazard_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  logic              sys_clk = 1'b0;
  logic              rstn;
  logic              if_busy, stallreq_mem;
  logic              id_rs1_re, id_rs2_re;
  logic [4:0]        id_rs1_addr, id_rs2_addr;
  logic              ex_mem_read;
  logic [4:0]        ex_rd_addr;
  logic              br_taken_ex;
  logic [31:0]       br_target_ex;
  logic              exc_req;
  logic [31:0]       exc_vector;
  logic [4:0]        stall_o, flush_o;
  logic              pc_redirect_o;
  logic [31:0]       pc_redirect_addr_o;
  logic [CNT_W-1:0]  stall_cnt_o, flush_cnt_o;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .sys_clk            (sys_clk),
    .rstn               (rstn),
    .if_busy            (if_busy),
    .stallreq_mem       (stallreq_mem),
    .id_rs1_re          (id_rs1_re),
    .id_rs2_re          (id_rs2_re),
    .id_rs1_addr        (id_rs1_addr),
    .id_rs2_addr        (id_rs2_addr),
    .ex_mem_read        (ex_mem_read),
    .ex_rd_addr         (ex_rd_addr),
    .br_taken_ex        (br_taken_ex),
    .br_target_ex       (br_target_ex),
    .exc_req            (exc_req),
    .exc_vector         (exc_vector),
    .stall_o            (stall_o),
    .flush_o            (flush_o),
    .pc_redirect_o      (pc_redirect_o),
    .pc_redirect_addr_o (pc_redirect_addr_o),
    .stall_cnt_o        (stall_cnt_o),
    .flush_cnt_o        (flush_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    if_busy = 0; stallreq_mem = 0;
    id_rs1_re = 0; id_rs2_re = 0; id_rs1_addr = 0; id_rs2_addr = 0;
    ex_mem_read = 0; ex_rd_addr = 0;
    br_taken_ex = 0; br_target_ex = 0;
    exc_req = 0; exc_vector = 0;
  endtask

  // Advance one cycle; inputs are then driven 1ns after the rising edge.
  task automatic nxt();
    @(posedge sys_clk);
    #1;
  endtask

  // Outputs are combinational; sample them mid-cycle, away from both edges.
  task automatic out(input string tag, input logic [4:0] st, input logic [4:0] fl,
                     input logic rd, input logic [31:0] addr);
    #3;
    check({tag, ".stall"}, 32'(stall_o), 32'(st));
    check({tag, ".flush"}, 32'(flush_o), 32'(fl));
    check({tag, ".redir"}, 32'(pc_redirect_o), 32'(rd));
    check({tag, ".addr"},  pc_redirect_addr_o, addr);
  endtask

  task automatic cnt(input string tag, input int sc, input int fc);
    check({tag, ".stall_cnt"}, 32'(stall_cnt_o), 32'(sc));
    check({tag, ".flush_cnt"}, 32'(flush_cnt_o), 32'(fc));
  endtask

  initial begin
    idle();
    rstn = 0;
    repeat (2) nxt();

    // Reset state
    rstn = 1;
    out("reset", 5'b00000, 5'b00000, 0, 32'h0);
    cnt("reset", 0, 0);

    // Load-use via rs2: one cycle of stall, then released
    nxt(); ex_mem_read = 1; ex_rd_addr = 5; id_rs2_re = 1; id_rs2_addr = 5;
    id_rs1_re = 1; id_rs1_addr = 3;
    out("lu", 5'b00011, 5'b00100, 0, 32'h0);
    nxt(); idle();
    out("lu_after", 5'b00000, 5'b00000, 0, 32'h0);
    cnt("lu_after", 1, 0);

    // Load to x0 is not a hazard
    nxt(); ex_mem_read = 1; ex_rd_addr = 0; id_rs1_re = 1; id_rs1_addr = 0;
    out("rd0", 5'b00000, 5'b00000, 0, 32'h0);

    // Taken branch with fetch idle: same-cycle redirect
    nxt(); idle(); br_taken_ex = 1; br_target_ex = 32'h100;
    out("br", 5'b00000, 5'b00110, 1, 32'h100);
    nxt(); idle();
    out("br_after", 5'b00000, 5'b00000, 0, 32'h0);
    cnt("br_after", 1, 1);

    // Exception in RUN also clears EX/MEM
    nxt(); exc_req = 1; exc_vector = 32'h80;
    out("exc_run", 5'b00000, 5'b01110, 1, 32'h80);

    // Branch while fetch busy: latch, drain, redirect when fetch lands
    nxt(); idle(); br_taken_ex = 1; br_target_ex = 32'h200; if_busy = 1;
    out("brb_entry", 5'b00001, 5'b00110, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      nxt(); br_taken_ex = 1; br_target_ex = 32'h300; if_busy = 1;
      out("brb_drain", 5'b00001, 5'b00010, 0, 32'h0);
    end
    nxt(); idle();
    out("brb_redir", 5'b00000, 5'b00010, 1, 32'h200);
    nxt();
    out("brb_after", 5'b00000, 5'b00000, 0, 32'h0);
    cnt("brb_after", 5, 3);

    // Exception on the 2nd DRAIN cycle replaces the branch target
    nxt(); br_taken_ex = 1; br_target_ex = 32'h400; if_busy = 1;
    out("exd_entry", 5'b00001, 5'b00110, 0, 32'h0);
    nxt(); idle(); if_busy = 1;
    out("exd_d1", 5'b00001, 5'b00010, 0, 32'h0);
    nxt(); if_busy = 1; exc_req = 1; exc_vector = 32'h80;
    out("exd_d2", 5'b00001, 5'b01010, 0, 32'h0);
    nxt(); idle();
    out("exd_redir", 5'b00000, 5'b00010, 1, 32'h80);
    nxt();
    cnt("exd_after", 8, 4);

    // Memory stall defers the branch for two cycles
    for (int i = 0; i < 2; i++) begin
      nxt(); idle(); stallreq_mem = 1; br_taken_ex = 1; br_target_ex = 32'h500;
      out("mem_br", 5'b01111, 5'b10000, 0, 32'h0);
    end
    nxt(); idle(); br_taken_ex = 1; br_target_ex = 32'h500;
    out("mem_br_redir", 5'b00000, 5'b00110, 1, 32'h500);
    nxt(); idle();
    cnt("mem_br_after", 10, 5);

    // DRAIN with memory stall, then reset mid-DRAIN: no redirect
    nxt(); br_taken_ex = 1; br_target_ex = 32'h600; if_busy = 1;
    out("rst_entry", 5'b00001, 5'b00110, 0, 32'h0);
    nxt(); idle(); if_busy = 1; stallreq_mem = 1;
    out("drain_mem", 5'b01001, 5'b10010, 0, 32'h0);
    nxt(); idle(); rstn = 0;
    out("rst_drain", 5'b00000, 5'b00000, 0, 32'h0);
    nxt(); rstn = 1;
    out("rst_release", 5'b00000, 5'b00000, 0, 32'h0);
    cnt("rst_release", 0, 0);
    nxt();
    out("rst_run", 5'b00000, 5'b00000, 0, 32'h0);

    // Saturation: 17 stall cycles on a 4-bit counter stick at 15
    for (int i = 0; i < 17; i++) begin
      nxt(); if_busy = 1;
      if (i == 0) out("sat_busy", 5'b00001, 5'b00010, 0, 32'h0);
    end
    nxt(); idle();
    #3;
    cnt("sat", 15, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
